// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_long_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// EX-stage request/response bundle between the pipeline and the HI/LO unit.
interface mult_div_unit_if;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDOp, D1, D2, input Busy, HI, LO);
  modport slave  (input Start, MDOp, D1, D2, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit_md_calc.sv
// Combinational multiply/divide datapath producing {hi, lo} for one op.
module md_calc
  import mult_div_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] b_safe;
  logic [31:0] qu;
  logic [31:0] ru;

  // Products: sign-extend for MULT so the low 64 bits are the signed product.
  assign prod_s = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2};
  assign prod_u = {32'd0, d1} * {32'd0, d2};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_neg  = d1[31];
  assign b_neg  = d2[31];
  assign a_mag  = a_neg ? (32'd0 - d1) : d1;
  assign b_mag  = b_neg ? (32'd0 - d2) : d2;
  assign b_safe = (d2 == 32'd0) ? 32'd1 : d2;

  // Divider quotient/remainder (divisor forced non-zero; result discarded on /0).
  always_comb begin
    logic [31:0] bm_safe;
    bm_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / bm_safe;
    r_mag   = a_mag % bm_safe;
    q_s     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    r_s     = a_neg ? (32'd0 - r_mag) : r_mag;
    qu      = d1 / b_safe;
    ru      = d1 % b_safe;
  end

  // Select the {hi, lo} pair for the requested op.
  always_comb begin
    result      = 64'd0;
    div_by_zero = is_div_op(op) && (d2 == 32'd0);
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {r_s, q_s};
      MD_DIVU:  result = {ru, qu};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO unit: issue FSM, busy down-counter, operand latches and HI/LO registers.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
  input logic             clk,
  input logic             reset,
  mult_div_unit_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q;
  md_op_e           op_in;
  logic [31:0]      a_q, b_q;
  logic [31:0]      hi_q, lo_q;
  logic             issue, done, wr_hi, wr_lo;
  logic [63:0]      calc_result;
  logic             calc_dbz;

  assign op_in = md_op_e'(md.MDOp);

  md_calc u_md_calc (
    .op          (op_q),
    .d1          (a_q),
    .d2          (b_q),
    .result      (calc_result),
    .div_by_zero (calc_dbz)
  );

  // Next-state / counter control; Start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    done    = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (md.Start) begin
          if (is_long_op(op_in)) begin
            issue   = 1'b1;
            state_d = ST_RUN;
            cnt_d   = is_div_op(op_in) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end
          wr_hi = (op_in == MD_MTHI);
          wr_lo = (op_in == MD_MTLO);
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, operand latches and HI/LO registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        op_q <= op_in;
        a_q  <= md.D1;
        b_q  <= md.D2;
      end
      if (done && !calc_dbz) begin
        hi_q <= calc_result[63:32];
        lo_q <= calc_result[31:0];
      end
      if (wr_hi) hi_q <= md.D1;
      if (wr_lo) lo_q <= md.D1;
    end
  end

  assign md.Busy = (state_q == ST_RUN);
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule
